bubble_sort_seq: RTL and testbench
==================================

BUBBLE_SORT_SEQ -- requirements
Module: bubble_sort_seq

Interface
REQ-001 The block SHALL have parameter DIM, default 10, meaning number of elements per frame (legal range DIM >= 2).
REQ-002 The block SHALL have parameter WIDTH, default 8, meaning element width in bits, unsigned.
REQ-003 Port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-004 Port rst_n, input, 1: reset, asynchronous and active-low.
REQ-005 Port in_valid, input, 1: upstream element present on in_data.
REQ-006 Port in_ready, output, 1: block accepts an element this cycle.
REQ-007 Port in_data, input, WIDTH: unsorted element.
REQ-008 Port out_valid, output, 1: sorted element present on out_data.
REQ-009 Port out_ready, input, 1: downstream accepts out_data this cycle.
REQ-010 Port out_data, output, WIDTH: sorted element, smallest first.
REQ-011 Port out_last, output, 1: marks the final (DIM-1) element of a frame.
REQ-012 Port busy, output, 1: high in SORT and DRAIN states.

Function
REQ-013 The FSM SHALL have states LOAD, SORT, DRAIN only.
REQ-014 LOAD: in_ready=1; each cycle with in_valid&&in_ready stores in_data at index load_cnt, load_cnt increments.
REQ-015 On the handshake of the DIM-th element the FSM SHALL enter SORT next cycle; in_ready SHALL be 0 outside LOAD.
REQ-016 SORT: odd-even transposition, one phase per cycle; phase p even compares pairs (0,1),(2,3)...; p odd compares (1,2),(3,4)...
REQ-017 Each compared pair SHALL swap iff a[j] > a[j+1] (unsigned); equal elements SHALL NOT swap.
REQ-018 Without early exit, SORT SHALL last exactly DIM cycles, then enter DRAIN.
REQ-019 Latency: last input handshake at cycle T gives first out_valid at cycle T+DIM+1 (no early exit).
REQ-020 DRAIN: out_valid=1, out_data=a[out_cnt]; out_cnt advances only on out_valid&&out_ready.
REQ-021 out_data and out_last SHALL hold stable while out_valid&&!out_ready.
REQ-022 out_last SHALL be 1 exactly when out_cnt==DIM-1 in DRAIN.
REQ-023 After the out_last handshake the FSM SHALL return to LOAD next cycle with counters zeroed; no overlap of frames.
REQ-024 in_valid during SORT/DRAIN SHALL be ignored; out_ready outside DRAIN SHALL be ignored.

Reset
REQ-025 rst_n low SHALL immediately force state LOAD, load_cnt=0, phase=0, out_cnt=0, all array entries 0.
REQ-026 Reset values: in_ready=1 (once rst_n high), out_valid=0, out_last=0, out_data=0, busy=0.
REQ-027 Reset mid-frame SHALL discard the frame; no partial output after release.

Configuration
REQ-028 Macro BSORT_EARLY_EXIT_EN defined: SORT SHALL end after two consecutive phases with no swap, or after DIM phases, whichever first.
REQ-029 Macro BSORT_EARLY_EXIT_EN undefined: SORT SHALL always take exactly DIM cycles; the swap-tracking logic is absent.

Structure
REQ-030 Package bsort_pkg SHALL hold the state enum (LOAD, SORT, DRAIN) and a counter-width function ($clog2-based).
REQ-031 Sub-module bsort_cmp_swap (two WIDTH inputs -> min, max, swapped flag) SHALL be instantiated DIM-1 times, one per adjacent pair.

Verification
REQ-032 Load 5,3,9,1,7,0,8,2,6,4 (DIM=10, out_ready=1) -> out 0..9 in order; out_last only on 9; first out_valid 11 cycles after last input.
REQ-033 Load all 8'hAA -> ten outputs of 8'hAA; with BSORT_EARLY_EXIT_EN, SORT lasts 2 cycles.
REQ-034 Load 255,254,...,246 (reverse) -> out 246..255; SORT lasts 10 cycles in both configurations.
REQ-035 Toggle out_ready 1-0-0-1 during DRAIN -> out_data/out_last constant while stalled; no element lost or duplicated.
REQ-036 Assert rst_n low after 4 loads -> in_ready=1, out_valid=0 after release; next frame 1..10 sorts correctly.
REQ-037 in_valid held high during SORT with data 8'hFF -> output frame unaffected; in_ready=0 throughout SORT.

Source files
------------

// File: rtl/bsort_pkg.sv
// Shared definitions for the sequential bubble sorter.
//   state_t   : frame FSM states (LOAD, SORT, DRAIN)
//   cnt_width : bit width of a counter that indexes 0..n-1
package bsort_pkg;

   typedef enum logic [1:0] {
      LOAD  = 2'd0,
      SORT  = 2'd1,
      DRAIN = 2'd2
   } state_t;

   // Width needed to index n elements; never below one bit.
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n <= 32'd2) ? 32'd1 : $clog2(n);
   endfunction

endpackage

// File: rtl/bsort_cmp_swap.sv
// Compare-and-swap cell for one adjacent element pair.
//   a, b       : elements at index j and j+1
//   min_c      : smaller of the two (combinational)
//   max_c      : larger of the two (combinational)
//   swapped_c  : 1 when a > b, i.e. the pair is out of order
// Equal elements are left in place so the sort is stable.
module bsort_cmp_swap #(
   parameter int unsigned WIDTH = 8
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] min_c,
   output logic [WIDTH-1:0] max_c,
   output logic             swapped_c
);

   assign swapped_c = (a > b);
   assign min_c     = swapped_c ? b : a;
   assign max_c     = swapped_c ? a : b;

endmodule

// File: rtl/bubble_sort_seq.sv
// Sequential odd-even transposition sorter for frames of DIM unsigned elements.
// A frame is loaded one element per handshake, sorted one phase per cycle,
// then drained smallest-first with valid/ready flow control.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid/in_ready   : input handshake, in_data is the unsorted element
//   out_valid/out_ready : output handshake, out_data is the sorted element
//   out_last            : marks the final element of a drained frame
//   busy                : high while sorting or draining
// Optional build macro BSORT_EARLY_EXIT_EN: end SORT after two consecutive
// phases without any swap (or after DIM phases, whichever comes first).
module bubble_sort_seq
   import bsort_pkg::*;
#(
   parameter int unsigned DIM   = 10,
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_last,
   output logic             busy
);

   localparam int unsigned CW       = cnt_width(DIM);
   localparam logic [CW-1:0] LAST_IDX = CW'(DIM - 1);

   state_t           state_q,    state_d;
   logic [CW-1:0]    load_cnt_q, load_cnt_d;
   logic [CW-1:0]    phase_q,    phase_d;
   logic [CW-1:0]    out_cnt_q,  out_cnt_d;
   logic [WIDTH-1:0] arr_q [DIM];
   logic [WIDTH-1:0] arr_d [DIM];
   logic [WIDTH-1:0] arr_step [DIM];

   logic             in_ready_q,  in_ready_d;
   logic             out_valid_q, out_valid_d;
   logic             out_last_q,  out_last_d;
   logic [WIDTH-1:0] out_data_q,  out_data_d;
   logic             busy_q,      busy_d;

   logic [WIDTH-1:0] mn  [DIM-1];
   logic [WIDTH-1:0] mx  [DIM-1];
   logic [DIM-2:0]   swp;

`ifdef BSORT_EARLY_EXIT_EN
   logic             quiet_q, quiet_d;
   logic             any_swap;
`else
   logic             unused_swp;
   assign unused_swp = ^swp;
`endif

   // One compare-swap cell per adjacent pair, all fed from the current array.
   for (genvar g = 0; g < int'(DIM) - 1; g++) begin : g_cmp
      bsort_cmp_swap #(.WIDTH(WIDTH)) u_cmp (
         .a         (arr_q[g]),
         .b         (arr_q[g+1]),
         .min_c     (mn[g]),
         .max_c     (mx[g]),
         .swapped_c (swp[g])
      );
   end

   // Apply only the pairs whose lower index matches the phase parity.
   always_comb begin
      arr_step = arr_q;
`ifdef BSORT_EARLY_EXIT_EN
      any_swap = 1'b0;
`endif
      for (int j = 0; j < int'(DIM) - 1; j++) begin
         if (1'(j) == phase_q[0]) begin
            arr_step[j]   = mn[j];
            arr_step[j+1] = mx[j];
`ifdef BSORT_EARLY_EXIT_EN
            any_swap      = any_swap | swp[j];
`endif
         end
      end
   end

   // Next-state, counter, array and output logic.
   always_comb begin
      state_d    = state_q;
      load_cnt_d = load_cnt_q;
      phase_d    = phase_q;
      out_cnt_d  = out_cnt_q;
      arr_d      = arr_q;
`ifdef BSORT_EARLY_EXIT_EN
      quiet_d    = quiet_q;
`endif

      case (state_q)
         LOAD: begin
            if (in_valid && in_ready_q) begin
               arr_d[load_cnt_q] = in_data;
               if (load_cnt_q == LAST_IDX) begin
                  load_cnt_d = '0;
                  phase_d    = '0;
                  state_d    = SORT;
               end else begin
                  load_cnt_d = load_cnt_q + 1'b1;
               end
            end
         end

         SORT: begin
            arr_d   = arr_step;
            phase_d = phase_q + 1'b1;
`ifdef BSORT_EARLY_EXIT_EN
            quiet_d = ~any_swap;
            if ((phase_q == LAST_IDX) || (!any_swap && quiet_q)) begin
               quiet_d = 1'b0;
`else
            if (phase_q == LAST_IDX) begin
`endif
               phase_d   = '0;
               out_cnt_d = '0;
               state_d   = DRAIN;
            end
         end

         DRAIN: begin
            if (out_valid_q && out_ready) begin
               if (out_cnt_q == LAST_IDX) begin
                  out_cnt_d = '0;
                  state_d   = LOAD;
               end else begin
                  out_cnt_d = out_cnt_q + 1'b1;
               end
            end
         end

         default: state_d = LOAD;
      endcase

      // Outputs are registered from the next state so they line up with it.
      in_ready_d  = (state_d == LOAD);
      busy_d      = (state_d != LOAD);
      out_valid_d = (state_d == DRAIN);
      out_last_d  = out_valid_d && (out_cnt_d == LAST_IDX);
      out_data_d  = out_valid_d ? arr_d[out_cnt_d] : '0;
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= LOAD;
         load_cnt_q  <= '0;
         phase_q     <= '0;
         out_cnt_q   <= '0;
         for (int i = 0; i < int'(DIM); i++) arr_q[i] <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         out_data_q  <= '0;
         busy_q      <= 1'b0;
`ifdef BSORT_EARLY_EXIT_EN
         quiet_q     <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         load_cnt_q  <= load_cnt_d;
         phase_q     <= phase_d;
         out_cnt_q   <= out_cnt_d;
         arr_q       <= arr_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         out_last_q  <= out_last_d;
         out_data_q  <= out_data_d;
         busy_q      <= busy_d;
`ifdef BSORT_EARLY_EXIT_EN
         quiet_q     <= quiet_d;
`endif
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_last  = out_last_q;
   assign out_data  = out_data_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_bubble_sort_seq.sv
// Scoreboard bench for bubble_sort_seq (DIM=10, WIDTH=8): a driver loads
// directed frames and queues hand-sorted expectations; a monitor pops and
// compares on every output handshake, checks stall stability, first-output
// latency and that in_ready stays low while busy.
module tb_bubble_sort_seq;

   localparam int DIM = 10;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_data;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_data;
   logic       out_last;
   logic       busy;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int last_in_cyc = 0;
   int exp_lat = 0;

   logic [8:0] sb [$];

   bubble_sort_seq #(.DIM(DIM), .WIDTH(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_last  (out_last),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: compares outputs mid-cycle, away from the active edge.
   logic       held_v = 1'b0;
   logic [7:0] held_d;
   logic       held_l;
   logic       prev_ov = 1'b0;
   logic [8:0] exp_e;

   always @(negedge clk) begin
      if (!rst_n) begin
         held_v  = 1'b0;
         prev_ov = 1'b0;
      end else begin
         if (busy) begin
            checks++;
            if (in_ready) begin
               errors++;
               $display("FAIL in_ready_while_busy: got %0b, expected 0 (cyc %0d)", in_ready, cyc);
            end
         end
         if (held_v) begin
            checks++;
            if (!out_valid || out_data !== held_d || out_last !== held_l) begin
               errors++;
               $display("FAIL stall_hold: got v=%0b d=%h l=%0b, expected v=1 d=%h l=%0b",
                        out_valid, out_data, out_last, held_d, held_l);
            end
         end
         held_v = out_valid && !out_ready;
         held_d = out_data;
         held_l = out_last;

         if (out_valid && !prev_ov && exp_lat != 0) begin
            checks++;
            if (cyc - last_in_cyc != exp_lat) begin
               errors++;
               $display("FAIL latency: got %0d cycles, expected %0d", cyc - last_in_cyc, exp_lat);
            end
         end
         prev_ov = out_valid;

         if (out_valid && out_ready) begin
            checks++;
            if (sb.size() == 0) begin
               errors++;
               $display("FAIL unexpected_output: got d=%h l=%0b, expected no output", out_data, out_last);
            end else begin
               exp_e = sb.pop_front();
               if (out_data !== exp_e[8:1] || out_last !== exp_e[0]) begin
                  errors++;
                  $display("FAIL out_elem: got d=%h l=%0b, expected d=%h l=%0b",
                           out_data, out_last, exp_e[8:1], exp_e[0]);
               end
            end
         end
      end
   end

   task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, got, exp);
      end
   endtask

   // Load one frame, queue its expected output, and wait for it to drain.
   task automatic run_frame(input logic [7:0] din [DIM], input logic [7:0] exp [DIM],
                            input int lat, input bit stall, input bit junk);
      bit pat [4];
      int n;
      pat = '{1'b1, 1'b0, 1'b0, 1'b1};
      exp_lat = lat;
      for (int i = 0; i < DIM; i++) sb.push_back({exp[i], (i == DIM - 1)});
      for (int i = 0; i < DIM; i++) begin
         in_valid = 1'b1;
         in_data  = din[i];
         @(negedge clk);
         if (in_ready) last_in_cyc = cyc;
         @(posedge clk); #1;
      end
      in_valid = junk;
      in_data  = junk ? 8'hFF : 8'h00;
      n = 0;
      while (sb.size() != 0 && n < 200) begin
         if (stall) out_ready = pat[n % 4];
         if (junk && n == 12) in_valid = 1'b0;
         @(posedge clk); #1;
         n++;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL drain_timeout: got %0d pending, expected 0", sb.size());
         sb.delete();
      end
      repeat (2) @(posedge clk);
      #1;
      chk("back_to_load_in_ready", 8'(in_ready), 8'd1);
      chk("back_to_load_busy", 8'(busy), 8'd0);
   endtask

   logic [7:0] d1 [DIM], e1 [DIM], d2 [DIM], d3 [DIM], e3 [DIM];
   logic [7:0] d4 [DIM], e4 [DIM], d5 [DIM], e5 [DIM];
   int lat1, lat2;

   initial begin
      d1 = '{8'd5, 8'd3, 8'd9, 8'd1, 8'd7, 8'd0, 8'd8, 8'd2, 8'd6, 8'd4};
      e1 = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9};
      d2 = '{default: 8'hAA};
      d3 = '{8'd255, 8'd254, 8'd253, 8'd252, 8'd251, 8'd250, 8'd249, 8'd248, 8'd247, 8'd246};
      e3 = '{8'd246, 8'd247, 8'd248, 8'd249, 8'd250, 8'd251, 8'd252, 8'd253, 8'd254, 8'd255};
      d4 = '{8'd12, 8'd200, 8'd7, 8'd7, 8'd99, 8'd0, 8'd150, 8'd33, 8'd64, 8'd128};
      e4 = '{8'd0, 8'd7, 8'd7, 8'd12, 8'd33, 8'd64, 8'd99, 8'd128, 8'd150, 8'd200};
      d5 = '{8'd7, 8'd1, 8'd10, 8'd3, 8'd9, 8'd2, 8'd8, 8'd5, 8'd6, 8'd4};
      e5 = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9, 8'd10};
`ifdef BSORT_EARLY_EXIT_EN
      lat1 = 0;
      lat2 = 3;
`else
      lat1 = DIM + 1;
      lat2 = DIM + 1;
`endif

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_data   = 8'h00;
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_out_valid", 8'(out_valid), 8'd0);
      chk("reset_out_last", 8'(out_last), 8'd0);
      chk("reset_out_data", out_data, 8'h00);
      chk("reset_busy", 8'(busy), 8'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      chk("reset_in_ready", 8'(in_ready), 8'd1);
      @(posedge clk); #1;

      run_frame(d1, e1, lat1, 1'b0, 1'b0);
      run_frame(d2, d2, lat2, 1'b0, 1'b0);
      run_frame(d3, e3, DIM + 1, 1'b0, 1'b0);
      run_frame(d4, e4, 0, 1'b1, 1'b0);

      // Abort a frame after four loads.
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1;
         in_data  = d5[i];
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      rst_n    = 1'b0;
      @(negedge clk);
      chk("midreset_out_valid", 8'(out_valid), 8'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      chk("midreset_in_ready", 8'(in_ready), 8'd1);
      chk("midreset_out_valid_after", 8'(out_valid), 8'd0);
      repeat (4) @(posedge clk);
      #1;
      chk("midreset_no_output", 8'(out_valid), 8'd0);

      run_frame(d5, e5, DIM + 1, 1'b0, 1'b0);
      run_frame(d1, e1, 0, 1'b0, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
